// File: rtl/ez8_skip_pkg.sv
// Shared constants for the ez8 conditional-skip control path:
// skip opcodes, condition selectors and the sequencer state encoding.
package ez8_skip_pkg;

  localparam logic [3:0] OP_SKCOND = 4'b1010;
  localparam logic [3:0] OP_SKBS   = 4'b1011;
  localparam logic [3:0] OP_SKBC   = 4'b1100;

  localparam logic [2:0] SEL_EQZ = 3'd0;
  localparam logic [2:0] SEL_NEZ = 3'd1;
  localparam logic [2:0] SEL_LTZ = 3'd2;
  localparam logic [2:0] SEL_GEZ = 3'd3;
  localparam logic [2:0] SEL_GTZ = 3'd4;
  localparam logic [2:0] SEL_LEZ = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_EVAL      = 2'd2,
    ST_SQUASH    = 2'd3
  } skip_state_e;

  function automatic logic is_skip_op(input logic [3:0] op);
    return (op == OP_SKCOND) || (op == OP_SKBS) || (op == OP_SKBC);
  endfunction

endpackage

// File: rtl/skip_squash_counter.sv
// Loadable down-counter tracking how many following instructions remain
// to be squashed; 'last' flags the decrement that retires the final one.
module skip_squash_counter #(
  parameter int SKIP_DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic dec_en,
  output logic last
);

  logic [2:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= 3'(SKIP_DEPTH);
    end else if (dec_en && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign last = dec_en && (count == 3'd1);

endmodule

// File: rtl/skip_sequencer.sv
// Sequences ez8 conditional-skip instructions: waits for the operand, hands it
// to the external evaluator, then squashes the following instructions if taken.
module skip_sequencer #(
  parameter int SKIP_DEPTH = 1,
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic [3:0] issue_opcode,
  input  logic [2:0] issue_selector,
  input  logic       issue_direction,
  output logic       issue_ready,
  input  logic       rd_valid,
  input  logic [7:0] reg_value,
  input  logic [7:0] accum_value,
  output logic [3:0] calc_opcode,
  output logic [2:0] calc_selector,
  output logic       calc_direction,
  output logic [7:0] calc_reg,
  output logic [7:0] calc_accum,
  input  logic       calc_skip,
  input  logic       pipe_stall,
  input  logic       next_valid,
  output logic       next_kill,
  output logic       stall_out,
  output logic       skip_taken,
  output logic       timeout_err
);

  import ez8_skip_pkg::*;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(WAIT_LIMIT);

  skip_state_e state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        accept;
  logic        wait_hit;
  logic        take_skip;
  logic        squash_dec;
  logic        squash_last;

  assign accept     = (state == ST_IDLE) && issue_valid && is_skip_op(issue_opcode) && !flush;
  assign wait_hit   = (wait_cnt == WAIT_LAST);
  assign take_skip  = (state == ST_EVAL) && calc_skip && !flush;
  assign squash_dec = (state == ST_SQUASH) && next_valid && !pipe_stall && !flush;

  skip_squash_counter #(
    .SKIP_DEPTH(SKIP_DEPTH)
  ) u_squash (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (flush),
    .load   (take_skip),
    .dec_en (squash_dec),
    .last   (squash_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept) state_nxt = ST_WAIT_OPND;
      ST_WAIT_OPND: begin
        // A read arriving on the limit cycle still counts as in time.
        if (rd_valid)      state_nxt = ST_EVAL;
        else if (wait_hit) state_nxt = ST_IDLE;
      end
      ST_EVAL:      state_nxt = calc_skip ? ST_SQUASH : ST_IDLE;
      ST_SQUASH:    if (squash_last) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    issue_ready = 1'b0;
    stall_out   = 1'b0;
    next_kill   = 1'b0;
    case (state)
      ST_IDLE:      issue_ready = 1'b1;
      ST_WAIT_OPND: stall_out   = 1'b1;
      ST_EVAL:      stall_out   = 1'b1;
      ST_SQUASH:    next_kill   = next_valid && !flush;
      default:      issue_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_taken     <= 1'b0;
      timeout_err    <= 1'b0;
      wait_cnt       <= '0;
      calc_opcode    <= '0;
      calc_selector  <= '0;
      calc_direction <= 1'b0;
      calc_reg       <= '0;
      calc_accum     <= '0;
    end else begin
      skip_taken  <= take_skip;
      timeout_err <= (state == ST_WAIT_OPND) && !rd_valid && wait_hit && !flush;
      if (flush) begin
        wait_cnt <= '0;
      end else if (accept) begin
        calc_opcode    <= issue_opcode;
        calc_selector  <= issue_selector;
        calc_direction <= issue_direction;
        wait_cnt       <= '0;
      end else if ((state == ST_WAIT_OPND) && !rd_valid && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if ((state == ST_WAIT_OPND) && rd_valid && !flush) begin
        calc_reg   <= reg_value;
        calc_accum <= accum_value;
      end
    end
  end

endmodule

// File: tb/tb_skip_sequencer.sv
// Directed bench for skip_sequencer with a scoreboard of expected output events
// (skip_taken / timeout_err / next_kill) checked by an independent monitor.
module tb_skip_sequencer;
  import ez8_skip_pkg::*;

  localparam logic [2:0] EV_SKIP = 3'b100;
  localparam logic [2:0] EV_TMO  = 3'b010;
  localparam logic [2:0] EV_KILL = 3'b001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       issue_valid = 1'b0;
  logic [3:0] issue_opcode = '0;
  logic [2:0] issue_selector = '0;
  logic       issue_direction = 1'b0;
  logic       issue_ready;
  logic       rd_valid = 1'b0;
  logic [7:0] reg_value = '0;
  logic [7:0] accum_value = '0;
  logic [3:0] calc_opcode;
  logic [2:0] calc_selector;
  logic       calc_direction;
  logic [7:0] calc_reg;
  logic [7:0] calc_accum;
  logic       calc_skip;
  logic       pipe_stall = 1'b0;
  logic       next_valid = 1'b0;
  logic       next_kill;
  logic       stall_out;
  logic       skip_taken;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb[$];
  logic [2:0] ev;
  logic [2:0] ev_exp;

  always #5 clk = ~clk;

  skip_sequencer #(.SKIP_DEPTH(2), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_selector(issue_selector), .issue_direction(issue_direction),
    .issue_ready(issue_ready), .rd_valid(rd_valid), .reg_value(reg_value),
    .accum_value(accum_value), .calc_opcode(calc_opcode),
    .calc_selector(calc_selector), .calc_direction(calc_direction),
    .calc_reg(calc_reg), .calc_accum(calc_accum), .calc_skip(calc_skip),
    .pipe_stall(pipe_stall), .next_valid(next_valid), .next_kill(next_kill),
    .stall_out(stall_out), .skip_taken(skip_taken), .timeout_err(timeout_err)
  );

  // Stand-in for the external condition evaluator.
  function automatic logic eval_skip(input logic [3:0] op, input logic [2:0] sel,
                                     input logic dir, input logic [7:0] r, input logic [7:0] a);
    logic signed [7:0] v;
    v = dir ? r : a;
    case (op)
      OP_SKCOND: begin
        case (sel)
          SEL_EQZ: return v == 0;
          SEL_NEZ: return v != 0;
          SEL_LTZ: return v < 0;
          SEL_GEZ: return v >= 0;
          SEL_GTZ: return v > 0;
          SEL_LEZ: return v <= 0;
          default: return 1'b0;
        endcase
      end
      OP_SKBS: return v[sel];
      OP_SKBC: return !v[sel];
      default: return 1'b0;
    endcase
  endfunction

  assign calc_skip = eval_skip(calc_opcode, calc_selector, calc_direction, calc_reg, calc_accum);

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] sel, input logic dir);
    issue_valid = 1'b1;
    issue_opcode = op;
    issue_selector = sel;
    issue_direction = dir;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic operand(input logic [7:0] r, input logic [7:0] a);
    reg_value = r;
    accum_value = a;
    rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
  endtask

  // Monitor: every cycle with any output event pops one expected event.
  always @(negedge clk) begin
    if (reset_n) begin
      ev = {skip_taken, timeout_err, next_kill};
      if (ev != 3'b000) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got %b expected none", ev);
        end else begin
          ev_exp = sb.pop_front();
          if (ev !== ev_exp) begin
            errors++;
            $display("FAIL event_order got %b expected %b", ev, ev_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_issue_ready", issue_ready, 1'b1);
    check1("rst_stall_out", stall_out, 1'b0);
    check1("rst_skip_taken", skip_taken, 1'b0);
    check1("rst_timeout_err", timeout_err, 1'b0);
    check8("rst_calc_opcode", {4'd0, calc_opcode}, 8'h00);
    reset_n = 1'b1;
    step();

    // Taken skeqz on register value 0, two kills
    issue(OP_SKCOND, SEL_EQZ, 1'b1);
    check1("t1_issue_ready_wait", issue_ready, 1'b0);
    check1("t1_stall_wait", stall_out, 1'b1);
    step();
    sb.push_back(EV_SKIP);
    operand(8'h00, 8'h55);
    check1("t1_stall_eval", stall_out, 1'b1);
    check8("t1_calc_reg", calc_reg, 8'h00);
    check8("t1_calc_accum", calc_accum, 8'h55);
    step();
    check1("t1_stall_squash", stall_out, 1'b0);
    check1("t1_ready_squash", issue_ready, 1'b0);
    step();
    next_valid = 1'b1;
    sb.push_back(EV_KILL);
    step();
    sb.push_back(EV_KILL);
    step();
    next_valid = 1'b0;
    check1("t1_back_idle", issue_ready, 1'b1);
    step();

    // Not taken skbs bit 3 of accumulator 0
    issue(OP_SKBS, 3'd3, 1'b0);
    operand(8'hFF, 8'h00);
    step();
    next_valid = 1'b1;
    check1("t2_stall_dropped", stall_out, 1'b0);
    check1("t2_ready", issue_ready, 1'b1);
    step();
    next_valid = 1'b0;

    // Non-skip opcode and skip issued with flush are both ignored
    issue(4'b0011, 3'd0, 1'b1);
    check1("t2b_nonskip_ready", issue_ready, 1'b1);
    check1("t2b_nonskip_stall", stall_out, 1'b0);
    flush = 1'b1;
    issue(OP_SKCOND, SEL_EQZ, 1'b1);
    flush = 1'b0;
    check1("t2c_flush_issue_ready", issue_ready, 1'b1);
    check1("t2c_flush_issue_stall", stall_out, 1'b0);

    // Taken skgtz, squash with pipe_stall held for 3 cycles
    issue(OP_SKCOND, SEL_GTZ, 1'b1);
    sb.push_back(EV_SKIP);
    operand(8'h05, 8'h00);
    step();
    step();
    next_valid = 1'b1;
    pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(EV_KILL);
      step();
    end
    check1("t3_still_squash", issue_ready, 1'b0);
    pipe_stall = 1'b0;
    sb.push_back(EV_KILL);
    step();
    check1("t3_one_left", issue_ready, 1'b0);
    sb.push_back(EV_KILL);
    step();
    next_valid = 1'b0;
    check1("t3_back_idle", issue_ready, 1'b1);
    step();

    // Timeout after 4 wait cycles
    issue(OP_SKCOND, SEL_EQZ, 1'b0);
    repeat (3) step();
    check1("t4_still_waiting", stall_out, 1'b1);
    sb.push_back(EV_TMO);
    step();
    check1("t4_idle_ready", issue_ready, 1'b1);
    check1("t4_idle_stall", stall_out, 1'b0);
    step();

    // rd_valid on the limit cycle wins over the timeout
    issue(OP_SKCOND, SEL_NEZ, 1'b1);
    repeat (3) step();
    operand(8'h00, 8'h00);
    check1("t4b_eval_stall", stall_out, 1'b1);
    check1("t4b_eval_ready", issue_ready, 1'b0);
    step();
    check1("t4b_idle", issue_ready, 1'b1);

    // Taken skbc bit 7 on accumulator
    issue(OP_SKBC, 3'd7, 1'b0);
    sb.push_back(EV_SKIP);
    operand(8'hFF, 8'h7F);
    step();
    step();
    next_valid = 1'b1;
    sb.push_back(EV_KILL);
    step();
    next_valid = 1'b0;
    step();
    next_valid = 1'b1;
    sb.push_back(EV_KILL);
    step();
    next_valid = 1'b0;
    check1("t5_skbc_idle", issue_ready, 1'b1);

    // Flush during SQUASH suppresses the kill
    issue(OP_SKCOND, SEL_LTZ, 1'b1);
    sb.push_back(EV_SKIP);
    operand(8'h80, 8'h00);
    step();
    step();
    next_valid = 1'b1;
    flush = 1'b1;
    #1;
    check1("t6_flush_no_kill", next_kill, 1'b0);
    step();
    flush = 1'b0;
    next_valid = 1'b0;
    check1("t6_ready_after_flush", issue_ready, 1'b1);
    step();

    // Asynchronous reset while waiting for the operand
    issue(OP_SKBS, 3'd1, 1'b1);
    check1("t7_waiting", stall_out, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check1("t7_async_stall", stall_out, 1'b0);
    check1("t7_async_ready", issue_ready, 1'b1);
    check8("t7_async_opcode", {4'd0, calc_opcode}, 8'h00);
    step();
    reset_n = 1'b1;
    step();
    check1("t7_after_reset", issue_ready, 1'b1);

    repeat (3) step();
    check8("sb_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
